// File: rtl/fpu_if.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_if
//  Description : Operand/result bundle for the single-precision FPU.
//                The master drives operands and opcode and observes the
//                registered result; the slave is the FPU side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface fpu_if;
   logic [31:0] a;
   logic [31:0] b;
   logic [1:0]  opcode;
   logic [31:0] out;

   modport master (output a, output b, output opcode, input out);
   modport slave  (input a, input b, input opcode, output out);
endinterface
`default_nettype wire

// File: rtl/fpu.sv
`default_nettype none
// ============================================================================
//  Module      : fpu
//  Description : Single-cycle IEEE-754 binary32 ADD / SUB / MUL unit.
//                Combinational datapath into one result register.
//                Round-to-nearest-even, subnormal inputs read as zero,
//                underflowing results flushed to signed zero, canonical NaN.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu (
   input  wire logic [31:0] a,
   input  wire logic [31:0] b,
   input  wire logic [1:0]  opcode,
   input  wire logic        clk,
   output logic      [31:0] out,
   input  wire logic        rst
);

   localparam logic [31:0] C_QNAN   = 32'h7FC0_0000;
   localparam logic [1:0]  C_OP_ADD = 2'b00;
   localparam logic [1:0]  C_OP_SUB = 2'b01;
   localparam logic [1:0]  C_OP_MUL = 2'b10;

   logic [31:0] out_q;
   logic [31:0] out_d;

   // Leading-zero count of the 27-bit cancellation result (27 when all zero).
   function automatic logic [4:0] lzc27(input logic [26:0] v);
      logic [4:0] n;
      logic       done;
      n    = 5'd0;
      done = 1'b0;
      for (int i = 26; i >= 0; i--) begin
         if (!done) begin
            if (v[i]) done = 1'b1;
            else      n    = n + 5'd1;
         end
      end
      return n;
   endfunction

   // Round a normalised {mant[23:0], guard, round, sticky} to nearest-even,
   // then saturate to infinity or flush to signed zero on exponent range.
   function automatic logic [31:0] round_pack(input logic              s,
                                              input logic signed [9:0] e,
                                              input logic [26:0]       n);
      logic              up;
      logic [24:0]       mr;
      logic [22:0]       frac;
      logic signed [9:0] e_r;
      logic [31:0]       res;
      up = n[2] & (n[1] | n[0] | n[3]);
      mr = {1'b0, n[26:3]} + {24'd0, up};
      if (mr[24]) begin
         frac = mr[23:1];
         e_r  = e + 10'sd1;
      end else begin
         frac = mr[22:0];
         e_r  = e;
      end
      if (e_r >= 10'sd255)   res = {s, 8'hFF, 23'd0};
      else if (e_r < 10'sd1) res = {s, 31'd0};
      else                   res = {s, e_r[7:0], frac};
      return res;
   endfunction

   // Addition of two binary32 values; subtraction arrives with y's sign flipped.
   function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
      logic              sx, sy, sl, swap, eff_sub;
      logic [7:0]        ex, ey, el, es, dexp;
      logic [22:0]       fx, fy;
      logic              nan_x, nan_y, inf_x, inf_y, zero_x, zero_y;
      logic [23:0]       ml, ms;
      logic [26:0]       ext_s, shifted, lost_mask, aligned, dif, norm;
      logic [27:0]       sum;
      logic [4:0]        lz;
      logic signed [9:0] e_norm;
      logic [31:0]       res;

      sx = x[31]; ex = x[30:23]; fx = x[22:0];
      sy = y[31]; ey = y[30:23]; fy = y[22:0];
      nan_x  = (ex == 8'hFF) && (fx != 23'd0);
      nan_y  = (ey == 8'hFF) && (fy != 23'd0);
      inf_x  = (ex == 8'hFF) && (fx == 23'd0);
      inf_y  = (ey == 8'hFF) && (fy == 23'd0);
      zero_x = (ex == 8'd0);
      zero_y = (ey == 8'd0);

      // Order by magnitude so the difference path never goes negative.
      swap    = {ey, fy} > {ex, fx};
      sl      = swap ? sy : sx;
      el      = swap ? ey : ex;
      es      = swap ? ex : ey;
      ml      = swap ? {1'b1, fy} : {1'b1, fx};
      ms      = swap ? {1'b1, fx} : {1'b1, fy};
      eff_sub = sx ^ sy;

      // Align the smaller operand; bits falling off the end become sticky.
      dexp      = el - es;
      ext_s     = {ms, 3'b000};
      shifted   = ext_s >> dexp;
      lost_mask = (27'd1 << dexp) - 27'd1;
      if (dexp >= 8'd26) aligned = 27'd1;
      else               aligned = {shifted[26:1], shifted[0] | (|(ext_s & lost_mask))};

      sum = {1'b0, ml, 3'b000} + {1'b0, aligned};
      dif = {ml, 3'b000} - aligned;
      lz  = lzc27(dif);

      if (eff_sub) begin
         norm   = dif << lz;
         e_norm = $signed({2'b00, el}) - $signed({5'd0, lz});
      end else if (sum[27]) begin
         norm   = {sum[27:2], sum[1] | sum[0]};
         e_norm = $signed({2'b00, el}) + 10'sd1;
      end else begin
         norm   = sum[26:0];
         e_norm = $signed({2'b00, el});
      end

      if (nan_x || nan_y)                res = C_QNAN;
      else if (inf_x && inf_y)           res = eff_sub ? C_QNAN : {sx, 8'hFF, 23'd0};
      else if (inf_x)                    res = {sx, 8'hFF, 23'd0};
      else if (inf_y)                    res = {sy, 8'hFF, 23'd0};
      else if (zero_x && zero_y)         res = {sx & sy, 31'd0};
      else if (zero_x)                   res = {sy, ey, fy};
      else if (zero_y)                   res = {sx, ex, fx};
      else if (eff_sub && dif == 27'd0)  res = 32'd0;
      else                               res = round_pack(sl, e_norm, norm);
      return res;
   endfunction

   // Multiplication: 24x24 significand product, at most one normalising shift.
   function automatic logic [31:0] fp_mul(input logic [31:0] x, input logic [31:0] y);
      logic              sx, sy, sp;
      logic [7:0]        ex, ey;
      logic [22:0]       fx, fy;
      logic              nan_x, nan_y, inf_x, inf_y, zero_x, zero_y;
      logic [47:0]       p;
      logic [26:0]       norm;
      logic signed [9:0] e_sum, e_norm;
      logic [31:0]       res;

      sx = x[31]; ex = x[30:23]; fx = x[22:0];
      sy = y[31]; ey = y[30:23]; fy = y[22:0];
      sp = sx ^ sy;
      nan_x  = (ex == 8'hFF) && (fx != 23'd0);
      nan_y  = (ey == 8'hFF) && (fy != 23'd0);
      inf_x  = (ex == 8'hFF) && (fx == 23'd0);
      inf_y  = (ey == 8'hFF) && (fy == 23'd0);
      zero_x = (ex == 8'd0);
      zero_y = (ey == 8'd0);

      p     = {24'd0, 1'b1, fx} * {24'd0, 1'b1, fy};
      e_sum = $signed({2'b00, ex}) + $signed({2'b00, ey}) - 10'sd127;
      if (p[47]) begin
         norm   = {p[47:24], p[23], p[22], |p[21:0]};
         e_norm = e_sum + 10'sd1;
      end else begin
         norm   = {p[46:23], p[22], p[21], |p[20:0]};
         e_norm = e_sum;
      end

      if (nan_x || nan_y)                          res = C_QNAN;
      else if ((inf_x && zero_y) || (inf_y && zero_x)) res = C_QNAN;
      else if (inf_x || inf_y)                     res = {sp, 8'hFF, 23'd0};
      else if (zero_x || zero_y)                   res = {sp, 31'd0};
      else                                         res = round_pack(sp, e_norm, norm);
      return res;
   endfunction

   // Select the operation result; the reserved opcode yields +0.
   always_comb begin
      out_d = 32'd0;
      case (opcode)
         C_OP_ADD: out_d = fp_add(a, b);
         C_OP_SUB: out_d = fp_add(a, {~b[31], b[30:0]});
         C_OP_MUL: out_d = fp_mul(a, b);
         default:  out_d = 32'd0;
      endcase
   end

   // Result register; reset overrides the result due at that edge.
   always_ff @(posedge clk) begin
      if (rst) out_q <= 32'd0;
      else     out_q <= out_d;
   end

   assign out = out_q;

endmodule
`default_nettype wire

// File: tb/tb_fpu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fpu
//  Description : Self-checking bench for fpu: directed vectors plus random
//                back-to-back streams against an exact-integer float model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fpu;

   localparam logic [31:0] C_QNAN = 32'h7FC0_0000;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   fpu_if bus ();

   always #5 clk = ~clk;

   fpu dut (
      .a      (bus.a),
      .b      (bus.b),
      .opcode (bus.opcode),
      .clk    (clk),
      .out    (bus.out),
      .rst    (rst)
   );

   // Round an exact value M * 2^(base-150) to binary32 (RNE, flush-to-zero).
   function automatic logic [31:0] round_ref(input logic s, input longint unsigned m, input int base);
      int p, sh, e;
      longint unsigned q, rem, half;
      p = 0;
      for (int i = 0; i < 64; i++) if (m[i]) p = i;
      sh = p - 23;
      if (sh > 0) begin
         q    = m >> sh;
         rem  = m & ((64'd1 << sh) - 64'd1);
         half = 64'd1 << (sh - 1);
         if (rem > half || (rem == half && q[0])) q = q + 1;
         if (q == (64'd1 << 24)) begin
            q  = q >> 1;
            sh = sh + 1;
         end
      end else begin
         q = m << (-sh);
      end
      e = base + sh;
      if (e >= 255) return {s, 8'hFF, 23'd0};
      if (e < 1)    return {s, 31'd0};
      return {s, e[7:0], q[22:0]};
   endfunction

   // Reference result computed from exact integer arithmetic on the operands.
   function automatic logic [31:0] ref_fp(input logic [31:0] x, input logic [31:0] y, input logic [1:0] op);
      logic sx, sy, sl, ss;
      int ex, ey, el, es, d;
      longint unsigned mx, my, ml, ms, m;
      bit nx, ny, ix, iy, zx, zy;
      if (op == 2'b11) return 32'd0;
      if (op == 2'b01) y[31] = ~y[31];
      sx = x[31]; ex = int'(x[30:23]); mx = {40'd0, 1'b1, x[22:0]};
      sy = y[31]; ey = int'(y[30:23]); my = {40'd0, 1'b1, y[22:0]};
      nx = (ex == 255) && (x[22:0] != 0);  ny = (ey == 255) && (y[22:0] != 0);
      ix = (ex == 255) && (x[22:0] == 0);  iy = (ey == 255) && (y[22:0] == 0);
      zx = (ex == 0);                      zy = (ey == 0);
      if (nx || ny) return C_QNAN;
      if (op == 2'b10) begin
         if ((ix && zy) || (iy && zx)) return C_QNAN;
         if (ix || iy) return {sx ^ sy, 8'hFF, 23'd0};
         if (zx || zy) return {sx ^ sy, 31'd0};
         return round_ref(sx ^ sy, mx * my, ex + ey - 150);
      end
      if (ix && iy) return (sx == sy) ? {sx, 8'hFF, 23'd0} : C_QNAN;
      if (ix) return {sx, 8'hFF, 23'd0};
      if (iy) return {sy, 8'hFF, 23'd0};
      if (zx && zy) return {sx & sy, 31'd0};
      if (zx) return y;
      if (zy) return x;
      if (ex > ey || (ex == ey && mx >= my)) begin
         sl = sx; el = ex; ml = mx; ss = sy; es = ey; ms = my;
      end else begin
         sl = sy; el = ey; ml = my; ss = sx; es = ex; ms = mx;
      end
      // Beyond 38 positions the small term sits far below half an ulp,
      // so clamping the distance cannot change the rounded result.
      d = el - es;
      if (d > 38) d = 38;
      if (sl == ss) m = (ml << d) + ms;
      else          m = (ml << d) - ms;
      if (m == 0) return 32'd0;
      return round_ref(sl, m, el - d);
   endfunction

   function automatic logic [31:0] rnd_val();
      logic [31:0] v;
      logic [7:0]  e;
      int unsigned sel;
      v   = $urandom;
      sel = $urandom_range(0, 15);
      case (sel)
         0:       return {v[31], 31'd0};
         1:       return {v[31], 8'hFF, 23'd0};
         2:       return {v[31], 8'hFF, v[22:0] | 23'd1};
         3:       return {v[31], 8'd0, v[22:0]};
         4:       e = 8'(250 + $urandom_range(0, 4));
         5:       e = 8'($urandom_range(1, 5));
         default: e = 8'($urandom_range(1, 254));
      endcase
      return {v[31], e, v[22:0]};
   endfunction

   // Second operand, often related to the first to provoke cancellation.
   function automatic logic [31:0] rnd_b(input logic [31:0] x);
      logic [31:0] v;
      int ev;
      v = $urandom;
      case ($urandom_range(0, 3))
         0:       return rnd_val();
         1:       return {v[31], x[30:0]};
         2: begin
            ev = int'(x[30:23]) + int'($urandom_range(0, 6)) - 3;
            if (ev < 1)   ev = 1;
            if (ev > 254) ev = 254;
            return {v[31], ev[7:0], v[22:0]};
         end
         default: return {v[31], x[30:4], v[3:0]};
      endcase
   endfunction

   task automatic test_reset();
      rst        = 1'b1;
      bus.a      = 32'h3F80_0000;
      bus.b      = 32'h4000_0000;
      bus.opcode = 2'b00;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_checks++;
         if (bus.out !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_hold cycle %0d: out=%h expected=%h", i, bus.out, 32'h0);
         end
      end
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (bus.out !== 32'h4040_0000) begin
         n_fail++;
         $display("FAIL reset_release: out=%h expected=%h", bus.out, 32'h4040_0000);
      end
   endtask

   task automatic test_directed();
      logic [31:0] va [28];
      logic [31:0] vb [28];
      logic [1:0]  vo [28];
      logic [31:0] ve [28];
      va = '{32'h3F800000, 32'h3F800000, 32'h40000000, 32'h40400000,
             32'h3F800000, 32'h3F800001, 32'h3FC00000,
             32'h7F800000, 32'h00000000, 32'h7FC00001, 32'h7F7FFFFF, 32'h00800000, 32'h3F800000,
             32'h7F800000, 32'hFF800000, 32'h3F800000, 32'h7F800000, 32'h80000000, 32'h80000000,
             32'h00000000, 32'h80000000, 32'h00000001, 32'h3F800000, 32'h00400000, 32'h7F000000,
             32'h00800001, 32'h00800000, 32'h3F000000};
      vb = '{32'h40000000, 32'h3F800000, 32'h40400000, 32'h3F800000,
             32'h33800000, 32'h33800000, 32'h3FC00000,
             32'hFF800000, 32'h7F800000, 32'h3F800000, 32'h7F7FFFFF, 32'h00800000, 32'h40000000,
             32'h7F800000, 32'h3F800000, 32'h7F800000, 32'hBF800000, 32'h3F800000, 32'h80000000,
             32'h80000000, 32'h00000000, 32'h3F800000, 32'hFFFFFFFF, 32'h7F800000, 32'h7F000000,
             32'h00800000, 32'h00800001, 32'h00800000};
      vo = '{2'b00, 2'b01, 2'b10, 2'b01,
             2'b00, 2'b00, 2'b10,
             2'b00, 2'b10, 2'b00, 2'b00, 2'b10, 2'b11,
             2'b01, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00,
             2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b10,
             2'b01, 2'b01, 2'b10};
      ve = '{32'h40400000, 32'h00000000, 32'h40C00000, 32'h40000000,
             32'h3F800000, 32'h3F800002, 32'h40100000,
             32'h7FC00000, 32'h7FC00000, 32'h7FC00000, 32'h7F800000, 32'h00000000, 32'h00000000,
             32'h7FC00000, 32'hFF800000, 32'hFF800000, 32'hFF800000, 32'h80000000, 32'h80000000,
             32'h00000000, 32'h80000000, 32'h3F800000, 32'h7FC00000, 32'h7FC00000, 32'h7F800000,
             32'h00000000, 32'h80000000, 32'h00000000};
      for (int i = 0; i < 28; i++) begin
         @(negedge clk);
         bus.a = va[i]; bus.b = vb[i]; bus.opcode = vo[i];
         @(negedge clk);
         n_checks++;
         if (bus.out !== ve[i]) begin
            n_fail++;
            $display("FAIL directed #%0d (a=%h b=%h op=%0d): out=%h expected=%h",
                     i, va[i], vb[i], vo[i], bus.out, ve[i]);
         end
      end
   endtask

   task automatic test_midstream_reset();
      @(negedge clk);
      bus.a = 32'h40000000; bus.b = 32'h40400000; bus.opcode = 2'b10;
      @(negedge clk);
      n_checks++;
      if (bus.out !== 32'h40C00000) begin
         n_fail++;
         $display("FAIL midreset_before: out=%h expected=%h", bus.out, 32'h40C00000);
      end
      rst = 1'b1;
      bus.a = 32'h3F800000; bus.b = 32'h40000000; bus.opcode = 2'b00;
      @(negedge clk);
      n_checks++;
      if (bus.out !== 32'h0) begin
         n_fail++;
         $display("FAIL midreset_discard: out=%h expected=%h", bus.out, 32'h0);
      end
      rst = 1'b0;
      bus.a = 32'h40400000; bus.b = 32'h3F800000; bus.opcode = 2'b01;
      @(negedge clk);
      n_checks++;
      if (bus.out !== 32'h40000000) begin
         n_fail++;
         $display("FAIL midreset_first: out=%h expected=%h", bus.out, 32'h40000000);
      end
   endtask

   task automatic test_back_to_back();
      logic [1:0]  ops  [7];
      logic [31:0] exps [7];
      ops  = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b10, 2'b01};
      exps = '{32'h40800000, 32'h40000000, 32'h40400000, 32'h00000000,
               32'h40800000, 32'h40400000, 32'h40000000};
      for (int i = 0; i <= 7; i++) begin
         @(negedge clk);
         if (i > 0) begin
            n_checks++;
            if (bus.out !== exps[i-1]) begin
               n_fail++;
               $display("FAIL opcode_switch #%0d op=%0d: out=%h expected=%h",
                        i - 1, ops[i-1], bus.out, exps[i-1]);
            end
         end
         if (i < 7) begin
            bus.a = 32'h40400000; bus.b = 32'h3F800000; bus.opcode = ops[i];
         end
      end
   endtask

   task automatic test_random(input logic [1:0] op, input int n, input string name);
      logic [31:0] exp_q, pa, pb;
      exp_q = 32'd0; pa = 32'd0; pb = 32'd0;
      for (int i = 0; i <= n; i++) begin
         @(negedge clk);
         if (i > 0) begin
            n_checks++;
            if (bus.out !== exp_q) begin
               n_fail++;
               $display("FAIL %s #%0d (a=%h b=%h): out=%h expected=%h",
                        name, i - 1, pa, pb, bus.out, exp_q);
            end
         end
         if (i < n) begin
            pa = rnd_val();
            pb = rnd_b(pa);
            bus.a = pa; bus.b = pb; bus.opcode = op;
            exp_q = ref_fp(pa, pb, op);
         end
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_midstream_reset();
      test_back_to_back();
      test_random(2'b00, 10000, "random_add");
      test_random(2'b01, 10000, "random_sub");
      test_random(2'b10, 5000,  "random_mul");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
